// File: rtl/uv_double_counter.sv
// Row-major (u, v) coefficient sequencer for an N x N DCT block.
// Saturates at (N-1, N-1) and raises done there until restart or reset.

module ff_en #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            Q <= rst_val;
        else if (en)
            Q <= D;
    end

endmodule

module uv_double_counter #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic          go,
    output logic [CW-1:0] u,
    output logic [CW-1:0] v,
    output logic          done
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ZERO = '0;

    logic [CW-1:0] u_d;
    logic [CW-1:0] v_d;
    logic          u_en;
    logic          v_en;
    logic          v_wrap;

    assign done   = (u == LAST) && (v == LAST);
    assign v_wrap = (v == LAST);

    // restart beats go; once saturated, go no longer loads either register
    always_comb begin
        u_d  = u;
        v_d  = v;
        u_en = 1'b0;
        v_en = 1'b0;
        if (restart) begin
            u_d  = ZERO;
            v_d  = ZERO;
            u_en = 1'b1;
            v_en = 1'b1;
        end else if (go && !done) begin
            v_en = 1'b1;
            if (v_wrap) begin
                v_d  = ZERO;
                u_d  = u + CW'(1);
                u_en = 1'b1;
            end else begin
                v_d  = v + CW'(1);
            end
        end
    end

    ff_en #(.WIDTH(CW)) u_reg (
        .clk     (clk),
        .rst     (rst),
        .en      (u_en),
        .rst_val (ZERO),
        .D       (u_d),
        .Q       (u)
    );

    ff_en #(.WIDTH(CW)) v_reg (
        .clk     (clk),
        .rst     (rst),
        .en      (v_en),
        .rst_val (ZERO),
        .D       (v_d),
        .Q       (v)
    );

endmodule

// File: tb/tb_uv_double_counter.sv
// Bench for uv_double_counter and ff_en: directed scenarios plus random go/restart
// traffic, compared against a linear position-index model.

module tb_uv_double_counter;

    localparam int N  = 8;
    localparam int CW = $clog2(N);
    localparam int NN = N * N;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          restart = 1'b0;
    logic          go = 1'b0;
    logic [CW-1:0] u;
    logic [CW-1:0] v;
    logic          done;

    logic       f_rst = 1'b0;
    logic       f_en = 1'b0;
    logic [3:0] f_d = 4'h0;
    logic [3:0] f_q;

    int checks = 0;
    int errors = 0;
    int k = 0;          // model: linear position index u*N + v
    int edges = 0;
    int done_edge = -1;

    always #5 clk = ~clk;

    uv_double_counter #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .go      (go),
        .u       (u),
        .v       (v),
        .done    (done)
    );

    ff_en #(.WIDTH(4)) f_dut (
        .clk     (clk),
        .rst     (f_rst),
        .en      (f_en),
        .rst_val (4'hA),
        .D       (f_d),
        .Q       (f_q)
    );

    task automatic check_pos(input string tag);
        logic [CW-1:0] eu;
        logic [CW-1:0] ev;
        logic          ed;
        eu = CW'(k / N);
        ev = CW'(k % N);
        ed = (k == NN - 1);
        checks++;
        assert (u === eu && v === ev && done === ed) else begin
            errors++;
            $error("FAIL %s: got u=%0d v=%0d done=%0d, expected u=%0d v=%0d done=%0d",
                   tag, u, v, done, eu, ev, ed);
        end
    endtask

    task automatic step(input logic r, input logic g, input string tag);
        @(negedge clk);
        restart = r;
        go      = g;
        @(posedge clk);
        if (r)
            k = 0;
        else if (g && k < NN - 1)
            k = k + 1;
        #1;
        check_pos(tag);
    endtask

    task automatic goto_pos(input int target);
        step(1'b1, 1'b0, "goto_restart");
        for (int i = 0; i < target; i++)
            step(1'b0, 1'b1, "goto_adv");
    endtask

    task automatic check_f(input logic [3:0] exp, input string tag);
        checks++;
        assert (f_q === exp) else begin
            errors++;
            $error("FAIL %s: got Q=%h, expected Q=%h", tag, f_q, exp);
        end
    endtask

    initial begin
        // reset state
        #12;
        check_pos("reset_state");
        @(negedge clk);
        rst = 1'b1;

        // full sweep: 1 restart cycle then 70 go cycles
        step(1'b1, 1'b0, "sweep_restart");
        edges = 0;
        for (int i = 0; i < 70; i++) begin
            step(1'b0, 1'b1, "sweep");
            edges++;
            if (done && done_edge < 0)
                done_edge = edges;
        end
        checks++;
        assert (done_edge === NN - 1) else begin
            errors++;
            $error("FAIL sweep_done_edge: got %0d, expected %0d", done_edge, NN - 1);
        end

        // row carry (2,7)->(3,0) and (6,7)->(7,0)
        goto_pos(2 * N + 7);
        step(1'b0, 1'b1, "carry_2_7");
        goto_pos(6 * N + 7);
        step(1'b0, 1'b1, "carry_6_7");

        // stall at (1,4)
        goto_pos(1 * N + 4);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, "stall_hold");
        step(1'b0, 1'b1, "stall_resume");

        // priority: restart with go, and restart from saturation
        goto_pos(5 * N + 2);
        step(1'b1, 1'b1, "prio_restart_go");
        goto_pos(NN - 1);
        step(1'b0, 1'b1, "saturate_hold");
        step(1'b1, 1'b0, "prio_restart_sat");

        // asynchronous reset mid-sweep at (3,5)
        goto_pos(3 * N + 5);
        @(negedge clk);
        go  = 1'b1;
        rst = 1'b0;
        k   = 0;
        #1;
        check_pos("async_reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        k = 1;
        #1;
        check_pos("resume_after_reset");

        // random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), "random");

        // ff_en unit
        @(negedge clk);
        f_rst = 1'b1;
        f_en  = 1'b1;
        f_d   = 4'h3;
        @(posedge clk);
        #1;
        f_rst = 1'b0;
        #1;
        check_f(4'hA, "ffen_async_rst");
        @(negedge clk);
        f_rst = 1'b1;
        f_en  = 1'b0;
        f_d   = 4'h5;
        @(posedge clk);
        #1;
        check_f(4'hA, "ffen_hold");
        @(negedge clk);
        f_en = 1'b1;
        @(posedge clk);
        #1;
        check_f(4'h5, "ffen_load");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
